// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high glyphs
// in {G,F,E,D,C,B,A} bit order, plus the all-segments-dark pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;  // 6 with the top bar (A) lit
  localparam logic [6:0] SEG_7   = 7'h07;  // 7 lights A, B, C
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;  // 9 with the bottom bar (D) lit
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;  // lower-case b
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;  // lower-case d
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph.
// Pin polarity is applied by the caller, not here.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  // Pure lookup from nibble to glyph
  always_comb begin
    glyph = SEG_OFF;
    case (hex)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. One digit slot lasts
// SCAN_DIV clocks. New data is staged in a pending register and only
// moves to the display register when the scan wraps to digit 0, so a
// frame never shows a mix of old and new digits. All pin outputs come
// straight from flops computed from the same next-state values, so the
// anode and segment lines always switch on the same edge.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1,
  parameter int LZB_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    blank,
  input  logic                    lzb_on,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;
  localparam bit AL    = (ACTIVE_LOW != 0);

  // Pin levels that mean "dark" for the configured polarity
  localparam logic [6:0]          SEG_PIN_OFF = AL ? 7'h7F : 7'h00;
  localparam logic                DP_PIN_OFF  = AL;
  localparam logic [N_DIGITS-1:0] AN_PIN_OFF  = AL ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  // Timebase and scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick, last_digit, wrap;

  // Staged and displayed data
  logic [DW-1:0]       pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0] pend_dp_q,   pend_dp_d;
  logic                pend_flag_q, pend_flag_d;
  logic [DW-1:0]       disp_data_q, disp_data_d;
  logic [N_DIGITS-1:0] disp_dp_q,   disp_dp_d;

  // Digit selection for the slot being entered
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [N_DIGITS-1:0] an_onehot;
  logic [N_DIGITS-1:0] lz_mask;
  logic [6:0]          glyph;
  logic [6:0]          seg_act;

  // Registered pins
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q, frame_done_d;

  // Tick counter wraps every SCAN_DIV clocks; index advances on each tick
  always_comb begin
    tick       = (cnt_q == CNT_W'(SCAN_DIV - 1));
    last_digit = (idx_q == IDX_W'(N_DIGITS - 1));
    wrap       = tick && last_digit;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
  end

  // Pending capture on load; display only updates at the frame wrap,
  // and a load on the wrap cycle itself bypasses the pending register
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (load) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        disp_data_d = data_in;
        disp_dp_d   = dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles are zero;
  // digit 0 always shows so a zero value still displays "0"
  always_comb begin
    logic run;
    run     = (LZB_EN != 0) && lzb_on;
    lz_mask = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (disp_data_d[4*k +: 4] != 4'h0) begin
        run = 1'b0;
      end
      lz_mask[k] = run;
    end
  end

  // Pick nibble, DP bit, blank flag and anode for the slot being entered
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    an_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        cur_nib      = disp_data_d[4*k +: 4];
        cur_dp       = disp_dp_d[k];
        cur_lz       = lz_mask[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .hex   (cur_nib),
    .glyph (glyph)
  );

  // Next pin values: blank overrides everything, else apply LZB and polarity
  always_comb begin
    seg_act      = cur_lz ? SEG_OFF : glyph;
    seg_d        = AL ? ~seg_act : seg_act;
    dp_d         = AL ? ~cur_dp : cur_dp;
    an_d         = AL ? ~an_onehot : an_onehot;
    frame_done_d = wrap;
    if (blank) begin
      seg_d = SEG_PIN_OFF;
      dp_d  = DP_PIN_OFF;
      an_d  = AN_PIN_OFF;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_PIN_OFF;
      dp_q         <= DP_PIN_OFF;
      an_q         <= AN_PIN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4 clocks per slot,
// active-low pins. Inputs change on falling edges, outputs are sampled on
// falling edges. After a frame_done sample the display sits at slot offset
// 0 of digit 0; digit k occupies offsets 4k..4k+3 of each 16-clock frame.
module tb_seg7_scan_driver;

  localparam int N_DIGITS = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic        lzb_on = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  seg7_scan_driver #(
    .N_DIGITS   (N_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (1),
    .LZB_EN     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .lzb_on     (lzb_on),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Clock: 10 time units per cycle
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next falling edge where frame_done is seen, bounded
  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL wait_fd: frame_done=%b required 1 within 40 clocks", frame_done);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic       exp_fd;
    int         slot;
    rst = 1'b1;
    step(2);
    n_cmp++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: seg=%h dp=%b an=%h fd=%b required seg=7f dp=1 an=f fd=0",
               seg, dp, an, frame_done);
    end
    rst = 1'b0;
    // Sample i follows release edge i; index bumps at edges 3, 7, 11, ...
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      slot   = ((i + 1) / 4) % 4;
      exp_an = ~(4'b0001 << slot);
      exp_fd = ((i % 16) == 15);
      n_cmp++;
      if (an !== exp_an || frame_done !== exp_fd || seg !== 7'h40) begin
        n_err++;
        $display("FAIL reset_scan[%0d]: an=%h fd=%b seg=%h required an=%h fd=%b seg=40",
                 i, an, frame_done, seg, exp_an, exp_fd);
      end
    end
  endtask

  task automatic test_load_sync();
    logic [6:0] exp_seg[4];
    exp_seg[0] = 7'h0E;  // F
    exp_seg[1] = 7'h08;  // A
    exp_seg[2] = 7'h24;  // 2
    exp_seg[3] = 7'h79;  // 1
    wait_fd();
    step(5);                       // mid digit 1
    pulse_load(16'h12AF, 4'b0000); // now offset 6
    step(3);                       // offset 9: digit 2, old data
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'hB) begin
      n_err++;
      $display("FAIL load_midframe_d2: seg=%h an=%h required seg=40 an=b", seg, an);
    end
    step(4);                       // offset 13: digit 3, old data
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'h7) begin
      n_err++;
      $display("FAIL load_midframe_d3: seg=%h an=%h required seg=40 an=7", seg, an);
    end
    wait_fd();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      n_cmp++;
      if (seg !== exp_seg[k] || an !== ~(4'b0001 << k) || dp !== 1'b1) begin
        n_err++;
        $display("FAIL load_newframe_d%0d: seg=%h an=%h dp=%b required seg=%h an=%h dp=1",
                 k, seg, an, dp, exp_seg[k], ~(4'b0001 << k));
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] exp_seg[4];
    wait_fd();
    step(2);
    pulse_load(16'h0000, 4'b0000);
    pulse_load(16'h0042, 4'b0000);
    lzb_on = 1'b1;
    wait_fd();
    exp_seg[0] = 7'h24;  // 2
    exp_seg[1] = 7'h19;  // 4
    exp_seg[2] = 7'h7F;  // leading zero, dark
    exp_seg[3] = 7'h7F;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      n_cmp++;
      if (seg !== exp_seg[k] || an !== ~(4'b0001 << k)) begin
        n_err++;
        $display("FAIL lzb_0042_d%0d: seg=%h an=%h required seg=%h an=%h",
                 k, seg, an, exp_seg[k], ~(4'b0001 << k));
      end
    end
    pulse_load(16'h0000, 4'b1000);
    wait_fd();
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'hE) begin
      n_err++;
      $display("FAIL lzb_zero_d0: seg=%h an=%h required seg=40 an=e", seg, an);
    end
    step(4);
    n_cmp++;
    if (seg !== 7'h7F || an !== 4'hD) begin
      n_err++;
      $display("FAIL lzb_zero_d1: seg=%h an=%h required seg=7f an=d", seg, an);
    end
    step(8);
    n_cmp++;
    if (seg !== 7'h7F || an !== 4'h7 || dp !== 1'b0) begin
      n_err++;
      $display("FAIL lzb_zero_d3_dp: seg=%h an=%h dp=%b required seg=7f an=7 dp=0",
               seg, an, dp);
    end
  endtask

  task automatic test_load_on_wrap();
    wait_fd();
    lzb_on = 1'b0;
    step(15);                      // offset 15: last clock of digit 3
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'h7) begin
      n_err++;
      $display("FAIL wrap_before: seg=%h an=%h required seg=40 an=7", seg, an);
    end
    load    = 1'b1;                // captured on the wrap edge
    data_in = 16'h8888;
    dp_in   = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_fd: frame_done=%b required 1", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      n_cmp++;
      if (seg !== 7'h00 || an !== ~(4'b0001 << k)) begin
        n_err++;
        $display("FAIL wrap_load_d%0d: seg=%h an=%h required seg=00 an=%h",
                 k, seg, an, ~(4'b0001 << k));
      end
    end
  endtask

  task automatic test_blank();
    wait_fd();
    step(10);
    blank = 1'b1;                  // outputs dark from offset 11
    for (int i = 11; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_done !== (i == 16)) begin
        n_err++;
        $display("FAIL blank[%0d]: seg=%h dp=%b an=%h fd=%b required seg=7f dp=1 an=f fd=%b",
                 i, seg, dp, an, frame_done, (i == 16));
      end
    end
    blank = 1'b0;                  // offset 20 of old frame = digit 1 of new frame
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h00 || an !== 4'hD || dp !== 1'b1) begin
      n_err++;
      $display("FAIL blank_resume: seg=%h an=%h dp=%b required seg=00 an=d dp=1", seg, an, dp);
    end
    step(11);                      // next frame start
    n_cmp++;
    if (frame_done !== 1'b1 || an !== 4'hE) begin
      n_err++;
      $display("FAIL blank_period: fd=%b an=%h required fd=1 an=e", frame_done, an);
    end
  endtask

  task automatic test_reset_midframe();
    wait_fd();
    step(5);
    pulse_load(16'h5555, 4'b1111);
    step(2);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: seg=%h dp=%b an=%h fd=%b required seg=7f dp=1 an=f fd=0",
               seg, dp, an, frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h40 || an !== 4'hE || dp !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_display: seg=%h an=%h dp=%b required seg=40 an=e dp=1", seg, an, dp);
    end
    wait_fd();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      n_cmp++;
      if (seg !== 7'h40 || dp !== 1'b1 || an !== ~(4'b0001 << k)) begin
        n_err++;
        $display("FAIL rst_pending_lost_d%0d: seg=%h dp=%b an=%h required seg=40 dp=1 an=%h",
                 k, seg, dp, an, ~(4'b0001 << k));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_sync();
    test_lzb();
    test_load_on_wrap();
    test_blank();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
